// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: default widths,
// opcode values and the sequencer state encoding.
package pc_sequencer_pkg;

  // Default geometry of the program store and the return stack
  localparam int ADDR_W      = 8;
  localparam int OP_W        = 4;
  localparam int INSTR_W     = 12;
  localparam int STACK_DEPTH = 4;

  // Opcode field values; 7..E are not listed and execute as NOP
  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_JMP  = 4'h1;
  localparam logic [OP_W-1:0] OP_JZ   = 4'h2;
  localparam logic [OP_W-1:0] OP_JNZ  = 4'h3;
  localparam logic [OP_W-1:0] OP_CALL = 4'h4;
  localparam logic [OP_W-1:0] OP_RET  = 4'h5;
  localparam logic [OP_W-1:0] OP_WAIT = 4'h6;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    WAITGO = 3'd3,
    HALTED = 3'd4
  } state_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Small LIFO holding return addresses for CALL/RET. The top entry is
// readable combinationally so RET can load it in the same cycle it pops.
module ret_stack
  import pc_sequencer_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int WIDTH = ADDR_W
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Push,
  input  logic             i_Pop,
  input  logic [WIDTH-1:0] i_Data,
  output logic [WIDTH-1:0] o_Top,
  output logic             o_Full,
  output logic             o_Empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   r_Count;
  logic [WIDTH-1:0] r_Mem [DEPTH];
  logic [PTR_W-1:0] w_WrIdx;
  logic [PTR_W-1:0] w_TopIdx;

  // The low count bits address the next free slot; the top sits one below
  // it, and the modulo wrap makes a full stack read its last slot.
  assign w_WrIdx  = r_Count[PTR_W-1:0];
  assign w_TopIdx = w_WrIdx - PTR_W'(1);
  assign o_Top    = r_Mem[w_TopIdx];
  assign o_Full   = (r_Count == (PTR_W+1)'(DEPTH));
  assign o_Empty  = (r_Count == '0);

  // Occupancy count; reset empties the stack, overfull/underflow requests are refused
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Count <= '0;
    end else if (i_Push && !o_Full) begin
      r_Count <= r_Count + (PTR_W+1)'(1);
    end else if (i_Pop && !o_Empty) begin
      r_Count <= r_Count - (PTR_W+1)'(1);
    end
  end

  // Entry storage; contents are don't-care once the count says they are free
  always_ff @(posedge i_Clk) begin
    if (!i_Reset && i_Push && !o_Full) begin
      r_Mem[w_WrIdx] <= i_Data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Control-side partner of the 8-bit program counter: fetches the instruction
// at the current counter value, decodes it and drives the counter's
// increment/load controls, with a hardware return stack for CALL/RET.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W      = pc_sequencer_pkg::ADDR_W,
  parameter int INSTR_W     = pc_sequencer_pkg::INSTR_W,
  parameter int STACK_DEPTH = pc_sequencer_pkg::STACK_DEPTH
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Start,
  input  logic               i_Go,
  input  logic               i_Zero,
  input  logic [ADDR_W-1:0]  i_PcIn,
  input  logic [INSTR_W-1:0] i_RomData,
  output logic [ADDR_W-1:0]  o_RomAddr,
  output logic               o_RomRe,
  output logic               o_CountEn,
  output logic               o_Load,
  output logic [ADDR_W-1:0]  o_Target,
  output logic               o_Busy,
  output logic               o_Halted,
  output logic               o_StackErr
);

  state_t            r_State;
  state_t            w_NextState;

  logic [ADDR_W-1:0] r_RomAddr;
  logic [ADDR_W-1:0] r_Target;
  logic              r_StackErr;

  logic [OP_W-1:0]   w_Opcode;
  logic [ADDR_W-1:0] w_Operand;
  logic [ADDR_W-1:0] w_RetAddr;

  logic              w_CountEn;
  logic              w_Load;
  logic [ADDR_W-1:0] w_LoadVal;
  logic              w_Push;
  logic              w_Pop;
  logic              w_SetErr;
  logic              w_RomRe;

  logic [ADDR_W-1:0] w_StackTop;
  logic              w_StackFull;
  logic              w_StackEmpty;

  // Instruction fields and the return address pushed by CALL (wraps at the top)
  assign w_Opcode  = i_RomData[INSTR_W-1 -: OP_W];
  assign w_Operand = i_RomData[ADDR_W-1:0];
  assign w_RetAddr = i_PcIn + ADDR_W'(1);

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_RetStack (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Push  (w_Push),
    .i_Pop   (w_Pop),
    .i_Data  (w_RetAddr),
    .o_Top   (w_StackTop),
    .o_Full  (w_StackFull),
    .o_Empty (w_StackEmpty)
  );

  // State register
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_State <= IDLE;
    end else begin
      r_State <= w_NextState;
    end
  end

  // Next state and per-cycle pulses; a pending reset suppresses every pulse
  always_comb begin
    w_NextState = r_State;
    w_CountEn   = 1'b0;
    w_Load      = 1'b0;
    w_LoadVal   = r_Target;
    w_Push      = 1'b0;
    w_Pop       = 1'b0;
    w_SetErr    = 1'b0;
    w_RomRe     = 1'b0;
    if (!i_Reset) begin
      case (r_State)
        IDLE: begin
          if (i_Start) begin
            w_NextState = FETCH;
          end
        end
        FETCH: begin
          w_RomRe     = 1'b1;
          w_NextState = EXEC;
        end
        EXEC: begin
          w_NextState = FETCH;
          case (w_Opcode)
            OP_NOP: begin
              w_CountEn = 1'b1;
            end
            OP_JMP: begin
              w_Load    = 1'b1;
              w_LoadVal = w_Operand;
            end
            OP_JZ: begin
              if (i_Zero) begin
                w_Load    = 1'b1;
                w_LoadVal = w_Operand;
              end else begin
                w_CountEn = 1'b1;
              end
            end
            OP_JNZ: begin
              if (!i_Zero) begin
                w_Load    = 1'b1;
                w_LoadVal = w_Operand;
              end else begin
                w_CountEn = 1'b1;
              end
            end
            OP_CALL: begin
              if (w_StackFull) begin
                w_SetErr    = 1'b1;
                w_NextState = HALTED;
              end else begin
                w_Push    = 1'b1;
                w_Load    = 1'b1;
                w_LoadVal = w_Operand;
              end
            end
            OP_RET: begin
              if (w_StackEmpty) begin
                w_SetErr    = 1'b1;
                w_NextState = HALTED;
              end else begin
                w_Pop     = 1'b1;
                w_Load    = 1'b1;
                w_LoadVal = w_StackTop;
              end
            end
            OP_WAIT: begin
              w_NextState = WAITGO;
            end
            OP_HALT: begin
              w_NextState = HALTED;
            end
            default: begin
              w_CountEn = 1'b1;
            end
          endcase
        end
        WAITGO: begin
          if (i_Go) begin
            w_CountEn   = 1'b1;
            w_NextState = FETCH;
          end
        end
        HALTED: begin
          w_NextState = HALTED;
        end
        default: begin
          w_NextState = IDLE;
        end
      endcase
    end
  end

  // Registered outputs: ROM address captured in FETCH, last load target, sticky stack error
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_RomAddr  <= '0;
      r_Target   <= '0;
      r_StackErr <= 1'b0;
    end else begin
      if (r_State == FETCH) begin
        r_RomAddr <= i_PcIn;
      end
      if (w_Load) begin
        r_Target <= w_LoadVal;
      end
      if (w_SetErr) begin
        r_StackErr <= 1'b1;
      end
    end
  end

  assign o_RomAddr  = r_RomAddr;
  assign o_RomRe    = w_RomRe;
  assign o_CountEn  = w_CountEn;
  assign o_Load     = w_Load;
  assign o_Target   = w_LoadVal;
  assign o_Busy     = (r_State == FETCH) || (r_State == EXEC) || (r_State == WAITGO);
  assign o_Halted   = (r_State == HALTED);
  assign o_StackErr = r_StackErr;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a behavioural program counter and ROM surround the
// sequencer; single-instruction vectors, hand-built sequences and random
// programs are checked against an instruction-level reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        go;
  logic        zero;
  logic [7:0]  pcIn;
  logic [11:0] romData;
  logic [7:0]  romAddr;
  logic        romRe;
  logic        countEn;
  logic        load;
  logic [7:0]  target;
  logic        busy;
  logic        halted;
  logic        stackErr;

  logic        presetEn;
  logic [7:0]  presetVal;
  logic [11:0] rom [256];

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state: program counter and return stack
  logic [7:0] mPc;
  logic [7:0] mStack [$];
  bit         mErr;
  bit         mHalted;

  typedef struct {
    logic [7:0]  startPc;
    logic [11:0] instr;
    bit          zeroIn;
    bit          expCnt;
    bit          expLoad;
    logic [7:0]  expTgt;
    logic [7:0]  expNextPc;
    bit          expHalted;
    bit          expErr;
    logic [7:0]  expRomAddr;
  } vec_t;

  vec_t vecs [14];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .i_Clk      (clk),
    .i_Reset    (reset),
    .i_Start    (start),
    .i_Go       (go),
    .i_Zero     (zero),
    .i_PcIn     (pcIn),
    .i_RomData  (romData),
    .o_RomAddr  (romAddr),
    .o_RomRe    (romRe),
    .o_CountEn  (countEn),
    .o_Load     (load),
    .o_Target   (target),
    .o_Busy     (busy),
    .o_Halted   (halted),
    .o_StackErr (stackErr)
  );

  // ROM data follows the registered address
  assign romData = rom[romAddr];

  // Program counter: preset by the bench, otherwise increments or loads on request
  always @(posedge clk) begin
    if (presetEn) pcIn <= presetVal;
    else if (countEn) pcIn <= pcIn + 8'd1;
    else if (load) pcIn <= target;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // Called at a negedge; returns at the following negedge with the DUT in IDLE
  task automatic doReset(input logic [7:0] startPc);
    reset = 1'b1; start = 1'b0; go = 1'b0; zero = 1'b0;
    presetEn = 1'b1; presetVal = startPc;
    @(negedge clk);
    reset = 1'b0; presetEn = 1'b0;
  endtask

  task automatic kickStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic modelInit(input logic [7:0] p);
    mPc = p; mStack.delete(); mErr = 1'b0; mHalted = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    #1;
    checkOutput({tag, ".romAddr"},  32'(romAddr), 0);
    checkOutput({tag, ".romRe"},    32'(romRe), 0);
    checkOutput({tag, ".countEn"},  32'(countEn), 0);
    checkOutput({tag, ".load"},     32'(load), 0);
    checkOutput({tag, ".target"},   32'(target), 0);
    checkOutput({tag, ".busy"},     32'(busy), 0);
    checkOutput({tag, ".halted"},   32'(halted), 0);
    checkOutput({tag, ".stackErr"}, 32'(stackErr), 0);
  endtask

  // One instruction against the model; entered at a negedge in FETCH
  task automatic stepInstr(input bit zv, input int waitCycles);
    logic [11:0] ins;
    logic [3:0]  op;
    logic [7:0]  opd;
    logic [7:0]  expTgt;
    bit expCnt, expLoad, isWait, stop;
    zero = zv;
    #1;
    checkOutput("fetch.romRe", 32'(romRe), 1);
    checkOutput("fetch.pcIn", 32'(pcIn), 32'(mPc));
    @(negedge clk);
    #1;
    checkOutput("exec.romAddr", 32'(romAddr), 32'(mPc));
    ins = rom[mPc]; op = ins[11:8]; opd = ins[7:0];
    expCnt = 0; expLoad = 0; expTgt = 8'h00; isWait = 0; stop = 0;
    case (op)
      4'h1: begin expLoad = 1; expTgt = opd; end
      4'h2: if (zv) begin expLoad = 1; expTgt = opd; end else expCnt = 1;
      4'h3: if (!zv) begin expLoad = 1; expTgt = opd; end else expCnt = 1;
      4'h4: begin
        if (mStack.size() >= 4) begin stop = 1; mErr = 1; end
        else begin mStack.push_back(8'((mPc + 1) % 256)); expLoad = 1; expTgt = opd; end
      end
      4'h5: begin
        if (mStack.size() == 0) begin stop = 1; mErr = 1; end
        else begin expLoad = 1; expTgt = mStack.pop_back(); end
      end
      4'h6: isWait = 1;
      4'hF: stop = 1;
      default: expCnt = 1;
    endcase
    checkOutput("exec.countEn", 32'(countEn), 32'(expCnt));
    checkOutput("exec.load", 32'(load), 32'(expLoad));
    if (expLoad) begin
      checkOutput("exec.target", 32'(target), 32'(expTgt));
      mPc = expTgt;
    end else if (expCnt) begin
      mPc = 8'((mPc + 1) % 256);
    end
    @(negedge clk);
    if (isWait) begin
      for (int k = 0; k < waitCycles; k++) begin
        #1;
        checkOutput("wait.countEn", 32'(countEn), 0);
        checkOutput("wait.load", 32'(load), 0);
        checkOutput("wait.busy", 32'(busy), 1);
        @(negedge clk);
      end
      go = 1'b1;
      #1;
      checkOutput("wait.goCountEn", 32'(countEn), 1);
      mPc = 8'((mPc + 1) % 256);
      @(negedge clk);
      go = 1'b0;
    end else if (stop) begin
      #1;
      checkOutput("halt.halted", 32'(halted), 1);
      checkOutput("halt.busy", 32'(busy), 0);
      checkOutput("halt.stackErr", 32'(stackErr), 32'(mErr));
      mHalted = 1'b1;
    end
  endtask

  // One table vector: a single instruction from a fresh reset
  task automatic applyStimulus(input vec_t v);
    doReset(v.startPc);
    rom[v.startPc] = v.instr;
    zero = v.zeroIn;
    kickStart();
    #1;
    checkOutput("vec.fetchRomRe", 32'(romRe), 1);
    @(negedge clk);
    #1;
    checkOutput("vec.countEn", 32'(countEn), 32'(v.expCnt));
    checkOutput("vec.load", 32'(load), 32'(v.expLoad));
    checkOutput("vec.target", 32'(target), 32'(v.expTgt));
    @(negedge clk);
    #1;
    checkOutput("vec.nextPc", 32'(pcIn), 32'(v.expNextPc));
    checkOutput("vec.halted", 32'(halted), 32'(v.expHalted));
    checkOutput("vec.busy", 32'(busy), 32'(!v.expHalted));
    checkOutput("vec.stackErr", 32'(stackErr), 32'(v.expErr));
    @(negedge clk);
    #1;
    checkOutput("vec.romAddr", 32'(romAddr), 32'(v.expRomAddr));
  endtask

  initial begin
    logic [3:0] op;
    reset = 1'b1; start = 1'b0; go = 1'b0; zero = 1'b0;
    presetEn = 1'b1; presetVal = 8'h00;
    for (int a = 0; a < 256; a++) rom[a] = 12'h000;

    // startPc instr zero cnt load tgt next halted err romAddr
    vecs[0]  = '{8'h00, 12'h000, 0, 1, 0, 8'h00, 8'h01, 0, 0, 8'h01};
    vecs[1]  = '{8'hFF, 12'h0AB, 0, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00};
    vecs[2]  = '{8'h10, 12'h140, 0, 0, 1, 8'h40, 8'h40, 0, 0, 8'h40};
    vecs[3]  = '{8'h40, 12'h280, 1, 0, 1, 8'h80, 8'h80, 0, 0, 8'h80};
    vecs[4]  = '{8'h40, 12'h280, 0, 1, 0, 8'h00, 8'h41, 0, 0, 8'h41};
    vecs[5]  = '{8'h22, 12'h3C0, 0, 0, 1, 8'hC0, 8'hC0, 0, 0, 8'hC0};
    vecs[6]  = '{8'h22, 12'h3C0, 1, 1, 0, 8'h00, 8'h23, 0, 0, 8'h23};
    vecs[7]  = '{8'h05, 12'h420, 0, 0, 1, 8'h20, 8'h20, 0, 0, 8'h20};
    vecs[8]  = '{8'hFF, 12'h411, 0, 0, 1, 8'h11, 8'h11, 0, 0, 8'h11};
    vecs[9]  = '{8'h30, 12'h500, 0, 0, 0, 8'h00, 8'h30, 1, 1, 8'h30};
    vecs[10] = '{8'h33, 12'hF00, 0, 0, 0, 8'h00, 8'h33, 1, 0, 8'h33};
    vecs[11] = '{8'h7A, 12'h9EE, 1, 1, 0, 8'h00, 8'h7B, 0, 0, 8'h7B};
    vecs[12] = '{8'h44, 12'h612, 0, 0, 0, 8'h00, 8'h44, 0, 0, 8'h44};
    vecs[13] = '{8'hA0, 12'hE55, 0, 1, 0, 8'h00, 8'hA1, 0, 0, 8'hA1};

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; presetEn = 1'b0;
    $display("[TB] reset state");
    checkResetState("reset0");

    $display("[TB] single-instruction vectors");
    foreach (vecs[i]) applyStimulus(vecs[i]);

    $display("[TB] NOP,NOP,HALT timing");
    @(negedge clk);
    doReset(8'h00);
    rom[0] = 12'h000; rom[1] = 12'h0FF; rom[2] = 12'hF00;
    for (int c = 0; c < 10; c++) begin
      start = (c == 0);
      #1;
      checkOutput("seq1.countEn", 32'(countEn), 32'((c == 2) || (c == 4)));
      checkOutput("seq1.halted", 32'(halted), 32'(c >= 7));
      checkOutput("seq1.busy", 32'(busy), 32'((c >= 1) && (c <= 6)));
      @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("seq1.startIgnoredHalted", 32'(halted), 1);
    checkOutput("seq1.startIgnoredBusy", 32'(busy), 0);

    $display("[TB] CALL/RET then RET on empty");
    @(negedge clk);
    doReset(8'h05);
    rom[8'h05] = 12'h420; rom[8'h20] = 12'h500; rom[8'h06] = 12'h500;
    modelInit(8'h05);
    kickStart();
    for (int i = 0; i < 3; i++) stepInstr(1'b0, 0);
    checkOutput("callret.haltedByEmpty", 32'(mHalted), 1);

    $display("[TB] five nested CALLs");
    @(negedge clk);
    doReset(8'h00);
    rom[8'h00] = 12'h410; rom[8'h10] = 12'h420; rom[8'h20] = 12'h430;
    rom[8'h30] = 12'h440; rom[8'h40] = 12'h450;
    modelInit(8'h00);
    kickStart();
    for (int i = 0; i < 5; i++) stepInstr(1'b0, 0);
    #1;
    checkOutput("overflow.stackErr", 32'(stackErr), 1);
    @(negedge clk);
    doReset(8'h00);
    checkResetState("resetAfterErr");

    $display("[TB] RET from a full stack");
    rom[8'h40] = 12'h500; rom[8'h31] = 12'hF00;
    modelInit(8'h00);
    kickStart();
    for (int i = 0; i < 6; i++) stepInstr(1'b0, 0);

    $display("[TB] CALL at 0xFF");
    @(negedge clk);
    doReset(8'hFF);
    rom[8'hFF] = 12'h460; rom[8'h60] = 12'h500; rom[8'h00] = 12'hF00;
    modelInit(8'hFF);
    kickStart();
    for (int i = 0; i < 3; i++) stepInstr(1'b0, 0);

    $display("[TB] WAIT with delayed Go");
    @(negedge clk);
    doReset(8'h30);
    rom[8'h30] = 12'h600; rom[8'h31] = 12'hF00;
    modelInit(8'h30);
    kickStart();
    stepInstr(1'b0, 10);
    stepInstr(1'b0, 0);

    $display("[TB] reset during EXEC of CALL");
    @(negedge clk);
    doReset(8'h05);
    rom[8'h05] = 12'h420;
    kickStart();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midReset.load", 32'(load), 0);
    checkOutput("midReset.countEn", 32'(countEn), 0);
    @(negedge clk);
    reset = 1'b0;
    checkResetState("midReset");
    checkOutput("midReset.pcHeld", 32'(pcIn), 8'h05);
    rom[8'h05] = 12'h500;
    modelInit(8'h05);
    kickStart();
    stepInstr(1'b0, 0);
    checkOutput("midReset.stackEmpty", 32'(mHalted), 1);

    $display("[TB] random programs");
    for (int run = 0; run < 20; run++) begin
      for (int a = 0; a < 256; a++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
        rom[a] = {op, 8'($urandom_range(0, 255))};
      end
      presetVal = 8'($urandom_range(0, 255));
      @(negedge clk);
      doReset(presetVal);
      modelInit(pcIn);
      kickStart();
      for (int i = 0; i < 40 && !mHalted; i++) begin
        stepInstr(1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
